// File: rtl/game_session_ctrl.sv
// game_session_ctrl: puzzle session FSM with elapsed-seconds timer, score capture and best-score tracking
module game_session_ctrl #(
  parameter int CLK_HZ = 50000000,
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        solved,
  input  logic        give_up,
  input  logic [6:0]  score_in,
  output logic [10:0] timer,
  output logic [2:0]  state,
  output logic [6:0]  final_score,
  output logic [6:0]  best_score,
  output logic        new_record,
  output logic        done
);
  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, PAUSED = 3'd2, SETTLE = 3'd3, DONE = 3'd4;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC - 1);
  logic [PW-1:0] presc;
  logic [SW-1:0] scnt;
  logic          wrap;
  assign wrap = presc == PMAX;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      presc <= '0;
      scnt <= '0;
      final_score <= '0;
      best_score <= '0;
      new_record <= 1'b0;
      done <= 1'b0;
    end else begin
      new_record <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= RUN;
          timer <= '0;
          presc <= '0;
          done <= 1'b0;
        end
        RUN, PAUSED: begin
          if (state == RUN) begin
            presc <= wrap ? '0 : presc + PW'(1);
            if (wrap && timer != 11'd2047) timer <= timer + 11'd1;
          end
          if (solved) begin
            state <= SETTLE;
            scnt <= '0;
          end else if (give_up) begin
            state <= DONE;
            final_score <= '0;
            done <= 1'b1;
          end else if (pause) state <= (state == RUN) ? PAUSED : RUN;
        end
        SETTLE: begin
          scnt <= scnt + SW'(1);
          // score_in has had SETTLE_CYC cycles to reflect the frozen timer
          if (scnt == SLAST) begin
            state <= DONE;
            done <= 1'b1;
            final_score <= score_in;
            if (score_in > best_score) begin
              best_score <= score_in;
              new_record <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: directed self-checking bench for game_session_ctrl (CLK_HZ=4, SETTLE_CYC=2)
module tb_game_session_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        solved = 1'b0;
  logic        give_up = 1'b0;
  logic [6:0]  score_in = '0;
  logic [10:0] timer;
  logic [2:0]  state;
  logic [6:0]  final_score;
  logic [6:0]  best_score;
  logic        new_record;
  logic        done;
  int checks = 0;
  int failures = 0;
  game_session_ctrl #(.CLK_HZ(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .solved(solved),
    .give_up(give_up), .score_in(score_in), .timer(timer), .state(state),
    .final_score(final_score), .best_score(best_score), .new_record(new_record), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_timer"}, timer, 0);
    chk({tag, "_final"}, final_score, 0);
    chk({tag, "_best"}, best_score, 0);
    chk({tag, "_rec"}, new_record, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  initial begin
    tick(2);
    reset = 1'b0;
    all_zero("rst");
    start = 1'b0; pause = 1'b1; solved = 1'b1; give_up = 1'b1;
    tick(1);
    pause = 1'b0; solved = 1'b0; give_up = 1'b0;
    chk("idle_ignore", state, 0);
    pulse_start();
    chk("start_state", state, 1);
    tick(40);
    chk("run40_timer", timer, 10);
    chk("run40_state", state, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    all_zero("rst_run");
    pulse_start();
    tick(6);
    chk("pre_pause_timer", timer, 1);
    pause = 1'b1; tick(1); pause = 1'b0;
    chk("paused_state", state, 2);
    pulse_start();
    tick(19);
    chk("paused_timer", timer, 1);
    chk("paused_start_ign", state, 2);
    pause = 1'b1; tick(1); pause = 1'b0;
    chk("resume_state", state, 1);
    tick(1);
    chk("partial_kept", timer, 2);
    tick(1);
    chk("resume2_timer", timer, 2);
    score_in = 7'd85;
    solved = 1'b1; tick(1); solved = 1'b0;
    chk("settle0", state, 3);
    tick(1);
    chk("settle1", state, 3);
    chk("settle1_timer", timer, 2);
    chk("settle1_done", done, 0);
    tick(1);
    chk("cap_state", state, 4);
    chk("cap_final", final_score, 85);
    chk("cap_best", best_score, 85);
    chk("cap_rec", new_record, 1);
    chk("cap_done", done, 1);
    tick(1);
    chk("rec_pulse_end", new_record, 0);
    chk("done_hold", done, 1);
    chk("done_timer", timer, 2);
    pulse_start();
    chk("s2_done_clr", done, 0);
    chk("s2_timer", timer, 0);
    solved = 1'b1; tick(1); solved = 1'b0;
    tick(2);
    chk("eq_state", state, 4);
    chk("eq_rec", new_record, 0);
    chk("eq_best", best_score, 85);
    pulse_start();
    score_in = 7'd90;
    solved = 1'b1; tick(1); solved = 1'b0;
    tick(2);
    chk("hi_rec", new_record, 1);
    chk("hi_best", best_score, 90);
    chk("hi_final", final_score, 90);
    pulse_start();
    solved = 1'b1; give_up = 1'b1; pause = 1'b1; tick(1);
    solved = 1'b0; give_up = 1'b0; pause = 1'b0;
    chk("prio_settle", state, 3);
    score_in = 7'd50;
    give_up = 1'b1; pause = 1'b1; start = 1'b1; tick(1);
    give_up = 1'b0; pause = 1'b0; start = 1'b0;
    chk("settle_ign", state, 3);
    tick(1);
    chk("low_final", final_score, 50);
    chk("low_rec", new_record, 0);
    chk("low_best", best_score, 90);
    pulse_start();
    give_up = 1'b1; tick(1); give_up = 1'b0;
    chk("gu_state", state, 4);
    chk("gu_final", final_score, 0);
    chk("gu_best", best_score, 90);
    chk("gu_done", done, 1);
    chk("gu_rec", new_record, 0);
    pulse_start();
    pause = 1'b1; tick(1); pause = 1'b0;
    give_up = 1'b1; tick(1); give_up = 1'b0;
    chk("gu_paused", state, 4);
    pulse_start();
    tick(8200);
    chk("sat_timer", timer, 2047);
    pulse_start();
    chk("run_start_ign", state, 1);
    chk("sat_hold", timer, 2047);
    give_up = 1'b1; tick(1); give_up = 1'b0;
    tick(5);
    chk("done_sat_hold", timer, 2047);
    pulse_start();
    chk("restart_timer", timer, 0);
    chk("restart_state", state, 1);
    score_in = 7'd120;
    solved = 1'b1; tick(1); solved = 1'b0;
    tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    all_zero("rst_settle");
    tick(2);
    chk("post_rst_best", best_score, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_session_ctrl.md
GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000: clock cycles per elapsed-time second.
REQ-002 Parameter SETTLE_CYC, default 2: cycles waited after timer freeze before score capture.
REQ-003 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a new session from IDLE or DONE.
REQ-006 pause  input  1  one-cycle pulse; toggles RUN<->PAUSED.
REQ-007 solved  input  1  one-cycle pulse; board solved, ends session with score.
REQ-008 give_up  input  1  one-cycle pulse; ends session with zero score.
REQ-009 score_in  input  7  registered score from the scoring block, derived from timer output.
REQ-010 timer  output  11  elapsed seconds of current session.
REQ-011 state  output  3  encoded FSM state: IDLE=0, RUN=1, PAUSED=2, SETTLE=3, DONE=4.
REQ-012 final_score  output  7  score captured at session end.
REQ-013 best_score  output  7  highest final_score since reset.
REQ-014 new_record  output  1  one-cycle pulse when best_score is updated.
REQ-015 done  output  1  high while state==DONE.

Function
REQ-016 Prescaler SHALL count 0..CLK_HZ-1 only in RUN, wrapping to 0 and incrementing timer on wrap.
REQ-017 Prescaler SHALL hold its value in PAUSED (pause does not lose partial seconds) and clear to 0 on start.
REQ-018 timer SHALL saturate at 2047, never wrap.
REQ-019 IDLE: start -> RUN, timer and prescaler cleared same edge; other inputs ignored.
REQ-020 RUN: solved -> SETTLE; else give_up -> DONE; else pause -> PAUSED (priority solved>give_up>pause).
REQ-021 PAUSED: solved -> SETTLE; else give_up -> DONE; else pause -> RUN; timer frozen.
REQ-022 SETTLE: timer frozen; after exactly SETTLE_CYC cycles in SETTLE, capture score_in into final_score and go to DONE.
REQ-023 SETTLE: start, pause, solved, give_up SHALL be ignored.
REQ-024 give_up path SHALL load final_score=0 on the edge entering DONE.
REQ-025 On capture in SETTLE, if score_in > best_score, best_score<=score_in and new_record=1 for that single cycle; equal score does not update.
REQ-026 DONE: timer, final_score held; start -> RUN with timer/prescaler cleared; final_score held until next capture or give_up.
REQ-027 start in RUN or PAUSED SHALL be ignored (no mid-session restart).
REQ-028 Any undefined state encoding SHALL return to IDLE next cycle.
REQ-029 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-030 reset SHALL override all inputs on the same edge: state=IDLE, timer=0, prescaler=0, final_score=0, best_score=0, new_record=0, done=0.
REQ-031 reset asserted mid-session (RUN, PAUSED, SETTLE) SHALL abort without score capture or best_score update.

Verification (CLK_HZ=4, SETTLE_CYC=2 for sim)
REQ-032 reset, start, 40 cycles RUN -> timer=10, state=1; reset -> all outputs 0 next edge.
REQ-033 start, 6 cycles, pause, 20 cycles, pause, 2 cycles -> timer=2 (partial second preserved), no increment while PAUSED.
REQ-034 solved with score_in=85 -> state=3 for 2 cycles, then final_score=85, best_score=85, new_record pulse 1 cycle, done=1.
REQ-035 second session solved with score_in=85 then third with 90 -> no new_record on equal, new_record and best_score=90 on third.
REQ-036 solved and give_up and pause same cycle in RUN -> SETTLE taken; give_up alone -> DONE, final_score=0, best_score unchanged.
REQ-037 timer forced near limit (long RUN) -> timer holds 2047; start in RUN ignored; start in DONE -> timer=0, state=1.
